// File: rtl/cla_pipelined_addsub_if.sv
// Operand/result handshake bus for cla_pipelined_addsub.
// The master drives operands and out_ready; the slave (the adder) drives results and in_ready.
interface cla_pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, zero
  );
endinterface

// File: rtl/cla_pipelined_addsub.sv
// Pipelined carry-look-ahead adder/subtractor: one GROUP-bit CLA slice per stage,
// carry registered between stages, whole pipe advances or stalls as a unit.
module cla_pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int GROUP = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  cla_pipelined_addsub_if.slave io_bus
);
  localparam int NSTG = WIDTH / GROUP;
  localparam int NG   = GROUP / 4;

  // 4-bit CLA blocks whose group generate/propagate feed a look-ahead unit.
  function automatic logic [GROUP:0] claSlice(input logic [GROUP-1:0] x,
                                               input logic [GROUP-1:0] y,
                                               input logic             cin);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] s;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;
    logic             c;
    g = x & y;
    p = x ^ y;
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
              (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    gc[0] = cin;
    for (int j = 0; j < NG; j++) begin
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    s = '0;
    for (int j = 0; j < NG; j++) begin
      c = gc[j];
      for (int i = 0; i < 4; i++) begin
        s[4*j+i] = p[4*j+i] ^ c;
        c        = g[4*j+i] | (p[4*j+i] & c);
      end
    end
    return {gc[NG], s};
  endfunction

  logic [WIDTH-1:0] r_a   [NSTG];
  logic [WIDTH-1:0] r_b   [NSTG];
  logic [WIDTH-1:0] r_sum [NSTG];
  logic [NSTG-1:0]  r_cy;
  logic [NSTG-1:0]  r_v;
  logic             r_ovf;
  logic             r_zero;

  logic [WIDTH-1:0] w_opA     [NSTG];
  logic [WIDTH-1:0] w_opB     [NSTG];
  logic [WIDTH-1:0] w_sumIn   [NSTG];
  logic [WIDTH-1:0] w_sumNext [NSTG];
  logic [GROUP:0]   w_res     [NSTG];
  logic [NSTG-1:0]  w_cin;
  logic [NSTG-1:0]  w_vIn;
  logic             w_adv;
  logic             w_msbCarry;

  assign w_adv = io_bus.out_ready | ~r_v[NSTG-1];

  // Stage 0 takes the live operands (B pre-inverted for subtract); later stages take their predecessor.
  always_comb begin
    w_opA[0]   = io_bus.a;
    w_opB[0]   = io_bus.b ^ {WIDTH{io_bus.sub}};
    w_sumIn[0] = '0;
    w_cin[0]   = io_bus.c_in ^ io_bus.sub;
    w_vIn[0]   = io_bus.in_valid;
    for (int k = 1; k < NSTG; k++) begin
      w_opA[k]   = r_a[k-1];
      w_opB[k]   = r_b[k-1];
      w_sumIn[k] = r_sum[k-1];
      w_cin[k]   = r_cy[k-1];
      w_vIn[k]   = r_v[k-1];
    end
    for (int k = 0; k < NSTG; k++) begin
      w_res[k]     = claSlice(w_opA[k][k*GROUP +: GROUP], w_opB[k][k*GROUP +: GROUP], w_cin[k]);
      w_sumNext[k] = w_sumIn[k];
      w_sumNext[k][k*GROUP +: GROUP] = w_res[k][GROUP-1:0];
    end
    w_msbCarry = w_opA[NSTG-1][WIDTH-1] ^ w_opB[NSTG-1][WIDTH-1] ^ w_sumNext[NSTG-1][WIDTH-1];
  end

  // Data registers only load behind a valid beat, so outputs hold their last result across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
      r_cy   <= '0;
      r_v    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < NSTG; k++) begin
        r_v[k] <= w_vIn[k];
        if (w_vIn[k]) begin
          r_a[k]   <= w_opA[k];
          r_b[k]   <= w_opB[k];
          r_sum[k] <= w_sumNext[k];
          r_cy[k]  <= w_res[k][GROUP];
        end
      end
      if (w_vIn[NSTG-1]) begin
        r_ovf  <= w_msbCarry ^ w_res[NSTG-1][GROUP];
        r_zero <= (w_sumNext[NSTG-1] == '0);
      end
    end
  end

  assign io_bus.in_ready  = w_adv;
  assign io_bus.out_valid = r_v[NSTG-1];
  assign io_bus.sum       = r_sum[NSTG-1];
  assign io_bus.c_out     = r_cy[NSTG-1];
  assign io_bus.ovf       = r_ovf;
  assign io_bus.zero      = r_zero;
endmodule
